// File: rtl/ghost_mode_scheduler.sv
// Ghost behaviour-mode scheduler: turns the divider's slow_clk into one-second ticks
// and sequences scatter/chase rounds, frightened mode and direction reversals.
module ghost_mode_scheduler #(
  parameter int SCATTER_SEC = 7,
  parameter int CHASE_SEC   = 20,
  parameter int FRIGHT_SEC  = 6,
  parameter int FLASH_SEC   = 2,
  parameter int NUM_ROUNDS  = 4,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             slow_clk,
  input  logic             start_level,
  input  logic             power_pellet,
  input  logic             pause,
  output logic [1:0]       mode,
  output logic             fright_flash,
  output logic             reverse_pulse,
  output logic             sec_tick,
  output logic [CNT_W-1:0] seconds_left
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCATTER = 2'd1,
    CHASE   = 2'd2,
    FRIGHT  = 2'd3
  } state_e;

  localparam int ROUND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

  localparam logic [CNT_W-1:0]   SCATTER_CNT = CNT_W'(SCATTER_SEC);
  localparam logic [CNT_W-1:0]   CHASE_CNT   = CNT_W'(CHASE_SEC);
  localparam logic [CNT_W-1:0]   FRIGHT_CNT  = CNT_W'(FRIGHT_SEC);
  localparam logic [CNT_W-1:0]   FLASH_CNT   = CNT_W'(FLASH_SEC);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [ROUND_W-1:0] ROUND_ONE   = ROUND_W'(1);

  // Tick generation
  logic slow_meta_q;
  logic slow_sync_q;
  logic slow_prev_q;
  logic sec_tick_q;
  logic slow_rise;

  assign slow_rise = slow_sync_q & ~slow_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      slow_meta_q <= 1'b0;
      slow_sync_q <= 1'b0;
      slow_prev_q <= 1'b0;
      sec_tick_q  <= 1'b0;
    end else begin
      slow_meta_q <= slow_clk;
      slow_sync_q <= slow_meta_q;
      slow_prev_q <= slow_sync_q;
      sec_tick_q  <= slow_rise;
    end
  end

  // Mode state machine
  state_e             state_q,       state_d;
  logic [CNT_W-1:0]   cnt_q,         cnt_d;
  logic [ROUND_W-1:0] round_q,       round_d;
  logic               perm_q,        perm_d;
  state_e             saved_state_q, saved_state_d;
  logic [CNT_W-1:0]   saved_cnt_q,   saved_cnt_d;
  logic               saved_perm_q,  saved_perm_d;
  logic               reverse_q,     reverse_d;
  logic               phase_tick;

  // Permanent chase has no countdown, so ticks are simply dropped there.
  assign phase_tick = sec_tick_q && !pause && (state_q != IDLE) && !perm_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      round_q       <= '0;
      perm_q        <= 1'b0;
      saved_state_q <= IDLE;
      saved_cnt_q   <= '0;
      saved_perm_q  <= 1'b0;
      reverse_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      round_q       <= round_d;
      perm_q        <= perm_d;
      saved_state_q <= saved_state_d;
      saved_cnt_q   <= saved_cnt_d;
      saved_perm_q  <= saved_perm_d;
      reverse_q     <= reverse_d;
    end
  end

  // NOTE: every signal driven here gets a hold/default value first, so no path
  // through the branches leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    round_d       = round_q;
    perm_d        = perm_q;
    saved_state_d = saved_state_q;
    saved_cnt_d   = saved_cnt_q;
    saved_perm_d  = saved_perm_q;
    reverse_d     = 1'b0;

    if (start_level) begin
      state_d = SCATTER;
      cnt_d   = SCATTER_CNT;
      round_d = '0;
      perm_d  = 1'b0;
    end else if (power_pellet && (state_q != IDLE)) begin
      if (state_q == FRIGHT) begin
        cnt_d = FRIGHT_CNT;
      end else begin
        // A coincident tick is dropped, so the pre-tick count is what resumes.
        saved_state_d = state_q;
        saved_cnt_d   = cnt_q;
        saved_perm_d  = perm_q;
        state_d       = FRIGHT;
        cnt_d         = FRIGHT_CNT;
        perm_d        = 1'b0;
        reverse_d     = 1'b1;
      end
    end else if (phase_tick) begin
      if (cnt_q == CNT_ONE) begin
        case (state_q)
          SCATTER: begin
            state_d   = CHASE;
            reverse_d = 1'b1;
            if (round_q == LAST_ROUND) begin
              perm_d = 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = CHASE_CNT;
            end
          end
          CHASE: begin
            state_d   = SCATTER;
            cnt_d     = SCATTER_CNT;
            round_d   = round_q + ROUND_ONE;
            reverse_d = 1'b1;
          end
          FRIGHT: begin
            state_d = saved_state_q;
            cnt_d   = saved_cnt_q;
            perm_d  = saved_perm_q;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  assign mode          = state_q;
  assign seconds_left  = cnt_q;
  assign reverse_pulse = reverse_q;
  assign sec_tick      = sec_tick_q;
  assign fright_flash  = (state_q == FRIGHT) && (cnt_q != '0) && (cnt_q <= FLASH_CNT);

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Bench for ghost_mode_scheduler: directed scenarios followed by random traffic,
// all checked every cycle against a phase/elapsed-time model of the schedule.
module tb_ghost_mode_scheduler;

  localparam int SC = 3;
  localparam int CH = 4;
  localparam int FR = 3;
  localparam int FL = 1;
  localparam int NR = 2;
  localparam int CW = 3;

  localparam int M_IDLE    = 0;
  localparam int M_SCATTER = 1;
  localparam int M_CHASE   = 2;
  localparam int M_FRIGHT  = 3;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          slow_clk = 1'b0;
  logic          start_level = 1'b0;
  logic          power_pellet = 1'b0;
  logic          pause = 1'b0;
  logic [1:0]    mode;
  logic          fright_flash;
  logic          reverse_pulse;
  logic          sec_tick;
  logic [CW-1:0] seconds_left;

  ghost_mode_scheduler #(
    .SCATTER_SEC(SC), .CHASE_SEC(CH), .FRIGHT_SEC(FR),
    .FLASH_SEC(FL), .NUM_ROUNDS(NR), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetN(resetN), .slow_clk(slow_clk),
    .start_level(start_level), .power_pellet(power_pellet), .pause(pause),
    .mode(mode), .fright_flash(fright_flash), .reverse_pulse(reverse_pulse),
    .sec_tick(sec_tick), .seconds_left(seconds_left)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus bookkeeping
  int edge_n = 0;
  int last_rise = -100;
  bit m_prev_slow = 1'b0;
  bit slow_run = 1'b0;
  int slow_phase = 0;
  bit in_reset = 1'b1;

  // Reference model: a phase of length m_len of which m_elapsed seconds are spent
  int m_mode = M_IDLE;
  int m_len = 0;
  int m_elapsed = 0;
  int m_scatters = 0;
  bit m_perm = 1'b0;
  int s_mode = M_IDLE;
  int s_left = 0;
  bit s_perm = 1'b0;
  bit exp_rev = 1'b0;
  bit exp_tick = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic int m_left();
    if (m_mode == M_IDLE || m_perm) return 0;
    return m_len - m_elapsed;
  endfunction

  function automatic bit m_flash();
    return (m_mode == M_FRIGHT) && (m_left() >= 1) && (m_left() <= FL);
  endfunction

  function automatic void model_clear();
    m_mode = M_IDLE; m_len = 0; m_elapsed = 0; m_scatters = 0; m_perm = 1'b0;
    last_rise = -100; m_prev_slow = 1'b0;
  endfunction

  function automatic void enter(input int md, input int len);
    m_mode = md; m_len = len; m_elapsed = 0;
  endfunction

  function automatic void model_edge(input bit st, input bit pp, input bit pz);
    bit tick_now;
    exp_rev = 1'b0;
    if (in_reset) begin
      model_clear();
      exp_tick = 1'b0;
      return;
    end
    // A rise first sampled at edge k shows on sec_tick after k+2 and is used at k+3.
    tick_now = (edge_n == last_rise + 3);
    exp_tick = (edge_n == last_rise + 2);
    if (slow_clk && !m_prev_slow) last_rise = edge_n;
    m_prev_slow = slow_clk;

    if (st) begin
      enter(M_SCATTER, SC);
      m_scatters = 1;
      m_perm = 1'b0;
    end else if (pp && m_mode != M_IDLE) begin
      if (m_mode == M_FRIGHT) begin
        enter(M_FRIGHT, FR);
      end else begin
        s_mode = m_mode; s_left = m_left(); s_perm = m_perm;
        enter(M_FRIGHT, FR);
        m_perm = 1'b0;
        exp_rev = 1'b1;
      end
    end else if (tick_now && !pz && m_mode != M_IDLE && !m_perm) begin
      m_elapsed++;
      if (m_elapsed == m_len) begin
        if (m_mode == M_SCATTER) begin
          exp_rev = 1'b1;
          if (m_scatters == NR) begin
            enter(M_CHASE, 0);
            m_perm = 1'b1;
          end else begin
            enter(M_CHASE, CH);
          end
        end else if (m_mode == M_CHASE) begin
          exp_rev = 1'b1;
          enter(M_SCATTER, SC);
          m_scatters++;
        end else begin
          enter(s_mode, s_left);
          m_perm = s_perm;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    check("mode", 32'(mode), 32'(m_mode));
    check("seconds_left", 32'(seconds_left), 32'(m_left()));
    check("fright_flash", 32'(fright_flash), 32'(m_flash()));
    check("reverse_pulse", 32'(reverse_pulse), 32'(exp_rev));
    check("sec_tick", 32'(sec_tick), 32'(exp_tick));
  endtask

  // One clock cycle: drive after the falling edge, model the rising edge, sample 1 ns later.
  task automatic step(input bit st, input bit pp, input bit pz);
    start_level = st;
    power_pellet = pp;
    pause = pz;
    if (slow_run) slow_phase = (slow_phase + 1) % 20;
    slow_clk = slow_run && (slow_phase >= 10);
    @(posedge clk);
    edge_n++;
    model_edge(st, pp, pz);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic wait_model(input int md, input int left, input bit need_tick, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (m_mode == md && m_left() == left && (!need_tick || edge_n + 1 == last_rise + 3))
        hit = 1'b1;
      else
        step(1'b0, 1'b0, 1'b0);
    end
    check({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise_e, tick_e, ticks, revs, flash_bad, flash_seen, held;
    int seg_mode[$];
    int seg_ticks[$];
    int prev_mode;
    bit exited, rst, pz, st, pp;

    @(negedge clk);
    // 1. Reset, quiet slow_clk, then tick generation
    repeat (3) step(1'b0, 1'b0, 1'b0);
    resetN = 1'b1;
    in_reset = 1'b0;
    repeat (30) step(1'b0, 1'b0, 1'b0);
    slow_run = 1'b1;
    slow_phase = 0;
    rise_e = -1; tick_e = -1; ticks = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (slow_clk && rise_e < 0) rise_e = edge_n;
      if (sec_tick) begin
        ticks++;
        if (tick_e < 0) tick_e = edge_n;
      end
    end
    check("tick_count", 32'(ticks), 32'd3);
    // Edge that samples sec_tick high, counted with the first slow_clk=1 sampling edge as 1st.
    check("tick_latency_edge", 32'(tick_e + 1 - rise_e + 1), 32'd4);

    // 2. Full schedule
    step(1'b1, 1'b0, 1'b0);
    seg_mode.push_back(int'(mode));
    seg_ticks.push_back(0);
    prev_mode = int'(mode);
    revs = 0;
    for (int i = 0; i < 260; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (int'(mode) != prev_mode) begin
        prev_mode = int'(mode);
        seg_mode.push_back(prev_mode);
        seg_ticks.push_back(0);
      end
      if (sec_tick) seg_ticks[seg_ticks.size() - 1]++;
      if (reverse_pulse) revs++;
    end
    check("sched_segments", 32'(seg_mode.size()), 32'd4);
    if (seg_mode.size() >= 4) begin
      check("sched_mode0", 32'(seg_mode[0]), 32'(M_SCATTER));
      check("sched_mode1", 32'(seg_mode[1]), 32'(M_CHASE));
      check("sched_mode2", 32'(seg_mode[2]), 32'(M_SCATTER));
      check("sched_mode3", 32'(seg_mode[3]), 32'(M_CHASE));
      check("sched_ticks0", 32'(seg_ticks[0]), 32'(SC));
      check("sched_ticks1", 32'(seg_ticks[1]), 32'(CH));
      check("sched_ticks2", 32'(seg_ticks[2]), 32'(SC));
    end
    check("sched_reverses", 32'(revs), 32'd3);
    check("perm_mode", 32'(mode), 32'(M_CHASE));
    check("perm_seconds_left", 32'(seconds_left), 32'd0);

    // 3. Pellet in CHASE at cnt=2, then resume
    step(1'b1, 1'b0, 1'b0);
    wait_model(M_CHASE, 2, 1'b0, "chase2");
    step(1'b0, 1'b1, 1'b0);
    check("pellet_mode", 32'(mode), 32'(M_FRIGHT));
    check("pellet_left", 32'(seconds_left), 32'(FR));
    check("pellet_reverse", 32'(reverse_pulse), 32'd1);
    flash_bad = 0; flash_seen = 0; exited = 1'b0;
    for (int i = 0; i < 120 && !exited; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (mode != 2'(M_FRIGHT)) exited = 1'b1;
      else if (fright_flash) begin
        flash_seen++;
        if (seconds_left != CW'(1)) flash_bad++;
      end
    end
    check("flash_only_at_1", 32'(flash_bad), 32'd0);
    check("flash_seen", 32'(flash_seen > 0), 32'd1);
    check("resume_mode", 32'(mode), 32'(M_CHASE));
    check("resume_left", 32'(seconds_left), 32'd2);
    check("resume_reverse", 32'(reverse_pulse), 32'd0);

    // 4. Pellet re-eaten while flashing
    step(1'b0, 1'b1, 1'b0);
    wait_model(M_FRIGHT, 1, 1'b0, "fright1");
    check("flash_before_reeat", 32'(fright_flash), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check("reeat_mode", 32'(mode), 32'(M_FRIGHT));
    check("reeat_left", 32'(seconds_left), 32'(FR));
    check("reeat_flash", 32'(fright_flash), 32'd0);
    check("reeat_reverse", 32'(reverse_pulse), 32'd0);
    wait_model(M_CHASE, 2, 1'b0, "reeat_resume");
    check("reeat_resume_mode", 32'(mode), 32'(M_CHASE));
    check("reeat_resume_left", 32'(seconds_left), 32'd2);

    // 5. Coincident events
    step(1'b1, 1'b0, 1'b0);
    wait_model(M_SCATTER, 1, 1'b1, "scatter1_tick");
    step(1'b0, 1'b1, 1'b0);
    check("coinc_mode", 32'(mode), 32'(M_FRIGHT));
    check("coinc_left", 32'(seconds_left), 32'(FR));
    wait_model(M_SCATTER, 1, 1'b0, "coinc_restore");
    check("coinc_restore_mode", 32'(mode), 32'(M_SCATTER));
    check("coinc_restore_left", 32'(seconds_left), 32'd1);
    wait_model(M_CHASE, 3, 1'b0, "chase3");
    step(1'b1, 1'b1, 1'b0);
    check("start_pellet_mode", 32'(mode), 32'(M_SCATTER));
    check("start_pellet_left", 32'(seconds_left), 32'(SC));
    check("start_pellet_reverse", 32'(reverse_pulse), 32'd0);

    // 6. Pause for five ticks, then asynchronous reset in FRIGHT
    held = m_left();
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (sec_tick) ticks++;
    end
    check("pause_ticks", 32'(ticks), 32'd5);
    check("pause_frozen", 32'(seconds_left), 32'(held));
    step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    check("pre_reset_mode", 32'(mode), 32'(M_FRIGHT));
    #2;
    resetN = 1'b0;
    in_reset = 1'b1;
    model_clear();
    exp_rev = 1'b0;
    exp_tick = 1'b0;
    #1;
    check("areset_mode", 32'(mode), 32'd0);
    check("areset_left", 32'(seconds_left), 32'd0);
    check("areset_flash", 32'(fright_flash), 32'd0);
    check("areset_reverse", 32'(reverse_pulse), 32'd0);
    check("areset_tick", 32'(sec_tick), 32'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    resetN = 1'b1;
    in_reset = 1'b0;

    // Random traffic against the model
    step(1'b1, 1'b0, 1'b0);
    pz = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 299) == 0);
      pp = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) pz = !pz;
      rst = ($urandom_range(0, 1499) == 0);
      if (rst) begin
        resetN = 1'b0;
        in_reset = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b0);
        resetN = 1'b1;
        in_reset = 1'b0;
        st = 1'b1;
      end
      step(st, pp, pz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
